spi_display_bridge: RTL and testbench
=====================================

SPI_DISPLAY_BRIDGE -- requirements
Module: spi_display_bridge

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning spi_clk half-period in clk cycles (legal range 1..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning entries in the transmit FIFO (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  system clock; all state advances on its rising edge.
REQ-004 SHALL have port rstb  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_valid  input  1  CPU-side write request.
REQ-006 SHALL have port o_ready  output  1  FIFO can accept a write.
REQ-007 SHALL have port i_data  input  8  byte to transmit.
REQ-008 SHALL have port i_dc  input  1  data/command flag sent with the byte (1 = data, 0 = command).
REQ-009 SHALL have port o_busy  output  1  FIFO non-empty or transfer in progress.
REQ-010 SHALL have port spi_clk  output  1  SPI clock, mode 0 (idle low).
REQ-011 SHALL have port spi_mosi  output  1  serial data out, MSB first.
REQ-012 SHALL have port spi_miso  input  1  serial data in.
REQ-013 SHALL have port display_csb  output  1  active-low chip select.
REQ-014 SHALL have port data_commandb  output  1  registered dc flag of the byte being shifted.
REQ-015 SHALL have port o_rx_data  output  8  last received byte (SPI_RX_EN only).
REQ-016 SHALL have port o_rx_valid  output  1  one-cycle strobe when o_rx_data updates (SPI_RX_EN only).

Function
REQ-017 SHALL push {i_dc,i_data} into the FIFO on any rising clk edge where i_valid && o_ready.
REQ-018 SHALL drive o_ready = !full combinationally; a write while full SHALL be dropped with no state change.
REQ-019 SHALL accept a push and a pop in the same cycle, including when full (pop frees the slot first only if also not full at push time: push when full is dropped).
REQ-020 SHALL implement states IDLE, SETUP, SHIFT, HOLD.
REQ-021 IDLE: csb=1, spi_clk=0; on FIFO non-empty, pop head, load shift register, set data_commandb and spi_mosi=bit7, csb=0, go SETUP — all in the same clk edge.
REQ-022 SETUP: wait CLK_DIV cycles with spi_clk low, then enter SHIFT.
REQ-023 SHIFT: toggle spi_clk every CLK_DIV cycles; on each falling edge shift next bit onto spi_mosi; after the 8th rising edge and its following falling edge (16*CLK_DIV cycles) the byte is complete.
REQ-024 At byte completion with FIFO non-empty: pop next entry, update data_commandb and spi_mosi in the same cycle, keep csb=0, stay in SHIFT (no SETUP gap).
REQ-025 At byte completion with FIFO empty: go HOLD; hold csb=0, spi_clk=0 for CLK_DIV cycles, then csb=1 and IDLE.
REQ-026 Total latency from first push into an idle block to csb falling SHALL be 2 clk cycles (push edge, then pop edge).
REQ-027 o_busy SHALL be 1 whenever state != IDLE or FIFO non-empty.
REQ-028 The divider counter SHALL wrap from CLK_DIV-1 to 0 and be reset to 0 on every state entry.

Reset
REQ-029 rstb low SHALL immediately force: FIFO empty, state IDLE, display_csb=1, spi_clk=0, spi_mosi=0, data_commandb=1, o_busy=0, o_ready=1, o_rx_data=0, o_rx_valid=0.
REQ-030 Reset asserted mid-byte SHALL abort the transfer without completing the byte; after release, no partial byte is re-sent.
REQ-031 Deassertion SHALL be used synchronously; first push accepted on the first rising edge with rstb high.

Configuration
REQ-032 With macro SPI_RX_EN defined, spi_miso SHALL be sampled on each spi_clk rising edge into a receive shift register, o_rx_data updated at byte completion and o_rx_valid pulsed high for exactly one cycle.
REQ-033 Without SPI_RX_EN, spi_miso SHALL be ignored, o_rx_data tied to 0 and o_rx_valid tied to 0.

Verification
REQ-034 Reset, then push 0x2A dc=0 (CLK_DIV=2) -> csb falls 1 cycle after push, data_commandb=0, 8 spi_clk pulses of period 4 clk, mosi bits 0,0,1,0,1,0,1,0, csb rises 36 cycles after falling.
REQ-035 Push 0x2C dc=0 then 0xF8,0x00 dc=1 back-to-back -> single csb low window of 3 bytes, data_commandb changes 0->1 between byte 1 and 2 while spi_clk low, no SETUP gap.
REQ-036 Push 6 bytes with i_valid held high, FIFO_DEPTH=4, idle start -> o_ready low after 5th accept (one popped), 6th accepted only after next pop; all 6 bytes appear on mosi in order.
REQ-037 Assert rstb low at 3rd spi_clk rising edge of byte 0xA5 -> csb=1, spi_clk=0 same instant, o_busy=0; after release no spi_clk activity without a new push.
REQ-038 With SPI_RX_EN, drive spi_miso with 0x5A MSB-first during transmit of 0xFF -> o_rx_data=0x5A and o_rx_valid high for exactly 1 cycle at byte completion; without macro both stay 0.
REQ-039 CLK_DIV=1, push 0x81 -> spi_clk toggles every clk cycle, byte completes in 16 cycles, mosi 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/spi_display_bridge.sv
// Write-only SPI bridge for a display controller: a small {dc,byte} FIFO feeding a mode-0 shifter.
// Define SPI_RX_EN to also capture spi_miso into o_rx_data/o_rx_valid.
module spi_display_bridge #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [7:0] i_data,
    input  logic       i_dc,
    output logic       o_busy,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       display_csb,
    output logic       data_commandb,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [7:0]    DivLast  = 8'(CLK_DIV - 1);
    localparam logic [CW-1:0] FifoFull = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

    // Transmit FIFO
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          fifo_full, fifo_empty, push, pop;
    logic [8:0]    head;

    assign fifo_full  = (count_q == FifoFull);
    assign fifo_empty = (count_q == '0);
    // A write while full is dropped even if the shifter pops in the same cycle.
    assign push       = i_valid && !fifo_full;
    assign head       = mem_q[rd_ptr_q];
    assign o_ready    = !fifo_full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {i_dc, i_data};
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Shifter FSM
    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] edge_q, edge_d;
    logic       sclk_q, sclk_d;
    logic [7:0] tx_q, tx_d;
    logic       dc_q, dc_d;
    logic       csb_q, csb_d;
    logic       div_done, rise_evt, byte_done;

    assign div_done = (cnt_q == DivLast);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            edge_q  <= 4'd0;
            sclk_q  <= 1'b0;
            tx_q    <= 8'd0;
            dc_q    <= 1'b1;
            csb_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            sclk_q  <= sclk_d;
            tx_q    <= tx_d;
            dc_q    <= dc_d;
            csb_q   <= csb_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = div_done ? 8'd0 : cnt_q + 8'd1;
        edge_d    = edge_q;
        sclk_d    = sclk_q;
        tx_d      = tx_q;
        dc_d      = dc_q;
        csb_d     = csb_q;
        pop       = 1'b0;
        rise_evt  = 1'b0;
        byte_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                csb_d  = 1'b1;
                sclk_d = 1'b0;
                cnt_d  = 8'd0;
                edge_d = 4'd0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    tx_d    = head[7:0];
                    dc_d    = head[8];
                    csb_d   = 1'b0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (div_done) begin
                    state_d = StShift;
                    edge_d  = 4'd0;
                end
            end
            StShift: begin
                if (div_done) begin
                    sclk_d = !sclk_q;
                    edge_d = edge_q + 4'd1;
                    if (!sclk_q) begin
                        rise_evt = 1'b1;
                    end else if (edge_q == 4'd15) begin
                        // Falling edge after the 8th rise: chain the next byte without a gap.
                        byte_done = 1'b1;
                        if (!fifo_empty) begin
                            pop  = 1'b1;
                            tx_d = head[7:0];
                            dc_d = head[8];
                        end else begin
                            tx_d    = 8'd0;
                            state_d = StHold;
                        end
                    end else begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end
            end
            StHold: begin
                if (div_done) begin
                    csb_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign spi_clk       = sclk_q;
    assign spi_mosi      = tx_q[7];
    assign display_csb   = csb_q;
    assign data_commandb = dc_q;
    assign o_busy        = (state_q != StIdle) || !fifo_empty;

`ifdef SPI_RX_EN
    logic [7:0] rx_sh_q, rx_data_q;
    logic       rx_valid_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rx_sh_q    <= 8'd0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= byte_done;
            if (rise_evt) begin
                rx_sh_q <= {rx_sh_q[6:0], spi_miso};
            end
            if (byte_done) begin
                rx_data_q <= rx_sh_q;
            end
        end
    end

    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;
`else
    logic unused_rx;
    assign unused_rx  = spi_miso ^ rise_evt ^ byte_done;
    assign o_rx_data  = 8'd0;
    assign o_rx_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spi_display_bridge.sv
// Bench for spi_display_bridge: lane 0 uses CLK_DIV=2, lane 1 uses CLK_DIV=1, both FIFO_DEPTH=4.
// A timeline model predicts every output each cycle; directed sequences pin the model with literals.
module tb_spi_display_bridge;

`ifdef SPI_RX_EN
    localparam bit RxEn = 1'b1;
`else
    localparam bit RxEn = 1'b0;
`endif
    localparam int Depth = 4;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rstb;
    logic       spi_miso;
    logic [1:0] valid, dc_in, ready, busy, sclk, mosi, csb, dcb, rxv;
    logic [7:0] data_in [2];
    logic [7:0] rxd [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int D = (g == 0) ? 2 : 1;

        logic [31:0] a_pack, e_pack;
        logic [8:0]  q[$];
        logic [8:0]  cur, pin;
        logic [7:0]  rx_acc, e_rxd;
        logic        e_rxv, e_dc, e_csb, e_sclk, e_mosi, push_ok;
        int          mode, off, s;
        bit          setup;

        spi_display_bridge #(
            .CLK_DIV   (D),
            .FIFO_DEPTH(Depth)
        ) u_dut (
            .clk          (clk),
            .rstb         (rstb),
            .i_valid      (valid[g]),
            .o_ready      (ready[g]),
            .i_data       (data_in[g]),
            .i_dc         (dc_in[g]),
            .o_busy       (busy[g]),
            .spi_clk      (sclk[g]),
            .spi_mosi     (mosi[g]),
            .spi_miso     (spi_miso),
            .display_csb  (csb[g]),
            .data_commandb(dcb[g]),
            .o_rx_data    (rxd[g]),
            .o_rx_valid   (rxv[g])
        );

        assign a_pack = {16'b0, rxd[g], 1'b0, rxv[g], ready[g], busy[g], dcb[g], mosi[g],
                         sclk[g], csb[g]};

        // mode 0 idle, 1 byte on the wire (off = cycles since byte start), 2 trailing hold
        initial begin
            e_pack = '0;
            forever begin
                @(posedge clk or negedge rstb);
                if (!rstb) begin
                    q.delete();
                    mode = 0; off = 0; setup = 1'b0; cur = '0;
                    rx_acc = '0; e_rxd = '0; e_rxv = 1'b0; e_dc = 1'b1;
                end else begin
                    push_ok = valid[g] && (q.size() < Depth);
                    pin     = {dc_in[g], data_in[g]};
                    e_rxv   = 1'b0;
                    if (mode == 0) begin
                        if (q.size() != 0) begin
                            cur = q.pop_front(); mode = 1; off = 0; setup = 1'b1; e_dc = cur[8];
                        end
                    end else if (mode == 1) begin
                        off++;
                        s = setup ? off - D : off;
                        if (s > 0 && s < 16 * D && (s % (2 * D)) == D)
                            rx_acc = {rx_acc[6:0], spi_miso};
                        if (s == 16 * D) begin
                            if (RxEn) begin
                                e_rxd = rx_acc; e_rxv = 1'b1;
                            end
                            if (q.size() != 0) begin
                                cur = q.pop_front(); off = 0; setup = 1'b0; e_dc = cur[8];
                            end else begin
                                mode = 2; off = 0;
                            end
                        end
                    end else begin
                        off++;
                        if (off == D) mode = 0;
                    end
                    if (push_ok) q.push_back(pin);
                end
                s      = (mode == 1 && setup) ? off - D : off;
                e_csb  = (mode == 0);
                e_sclk = 1'b0;
                e_mosi = 1'b0;
                if (mode == 1) begin
                    if (s >= 0) begin
                        e_sclk = ((s / D) % 2) == 1;
                        e_mosi = cur[7 - s / (2 * D)];
                    end else begin
                        e_mosi = cur[7];
                    end
                end
                e_pack = {16'b0, e_rxd, 1'b0, e_rxv, (q.size() < Depth),
                          (mode != 0 || q.size() != 0), e_dc, e_mosi, e_sclk, e_csb};
            end
        end
    end

    function automatic string fname(input int f);
        case (f)
            0: return "csb";
            1: return "spi_clk";
            2: return "mosi";
            3: return "dc";
            4: return "busy";
            5: return "ready";
            6: return "rx_valid";
            default: return "rx_data";
        endcase
    endfunction

    task automatic cmp_lane(input int lane, input logic [31:0] a, input logic [31:0] e);
        logic [7:0] av, ev;
        for (int f = 0; f < 8; f++) begin
            if (f == 7) begin
                av = a[15:8]; ev = e[15:8];
            end else begin
                av = {7'b0, a[f]}; ev = {7'b0, e[f]};
            end
            chk($sformatf("model_lane%0d_%s", lane, fname(f)), {24'b0, av}, {24'b0, ev});
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp_lane(0, g_lane[0].a_pack, g_lane[0].e_pack);
            cmp_lane(1, g_lane[1].a_pack, g_lane[1].e_pack);
        end
    end

    // Lane 0 byte monitor: mosi captured on each spi_clk rise while selected
    logic [7:0] mon_q[$];
    initial begin
        logic       ps;
        int         nb;
        logic [7:0] sh;
        ps = 1'b0; nb = 0; sh = '0;
        forever begin
            @(negedge clk or negedge rstb);
            if (!rstb) begin
                nb = 0; ps = 1'b0;
            end else begin
                if (!ps && sclk[0] && !csb[0]) begin
                    sh = {sh[6:0], mosi[0]};
                    nb++;
                    if (nb == 8) begin
                        mon_q.push_back(sh);
                        nb = 0;
                    end
                end
                ps = sclk[0];
            end
        end
    end

    int cyc, falls, csb_rises, lowcnt, sclk_rises, r1, r2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        falls = 0; csb_rises = 0; lowcnt = 0; sclk_rises = 0; r1 = 0; r2 = 0;
        mon_q.delete();
    endtask

    task automatic tick_obs();
        logic pc, ps;
        pc = csb[0];
        ps = sclk[0];
        tick();
        cyc++;
        if (pc && !csb[0]) falls++;
        if (!pc && csb[0]) csb_rises++;
        if (!csb[0]) lowcnt++;
        if (!ps && sclk[0]) begin
            sclk_rises++;
            if (sclk_rises == 1) r1 = cyc;
            if (sclk_rises == 2) r2 = cyc;
        end
    endtask

    task automatic wait_idle(input int lane, input int maxc);
        int n;
        n = 0;
        while (busy[lane] && n < maxc) begin
            tick_obs();
            n++;
        end
        chk($sformatf("idle_lane%0d", lane), {31'b0, busy[lane]}, 0);
    endtask

    task automatic check_bytes(input string nm, input bq_t ex);
        chk({nm, "_count"}, mon_q.size(), ex.size());
        for (int i = 0; i < ex.size(); i++)
            chk($sformatf("%s_byte%0d", nm, i), (i < mon_q.size()) ? {24'b0, mon_q[i]} : 32'hx,
                {24'b0, ex[i]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t        ex;
        logic [7:0] pat, got, b;
        int         idx, pulses, n, low, tog, acc5, k;
        logic       acc, ps;
        logic [7:0] vals [6];

        rstb = 1'b0; valid = '0; dc_in = '0; spi_miso = 1'b0;
        data_in[0] = '0; data_in[1] = '0;
        cyc = 0;
        clear_stats();
        repeat (3) tick();
        chk("reset_csb", csb[0], 1);
        chk("reset_spi_clk", sclk[0], 0);
        chk("reset_mosi", mosi[0], 0);
        chk("reset_dc", dcb[0], 1);
        chk("reset_busy", busy[0], 0);
        chk("reset_ready", ready[0], 1);
        chk("reset_rx_data", rxd[0], 0);
        chk("reset_rx_valid", rxv[0], 0);
        rstb = 1'b1;

        // Single command byte 0x2A
        clear_stats();
        valid[0] = 1'b1; data_in[0] = 8'h2A; dc_in[0] = 1'b0;
        tick_obs();
        valid[0] = 1'b0;
        chk("single_csb_after_push", csb[0], 1);
        tick_obs();
        chk("single_csb_fall", csb[0], 0);
        chk("single_dc", dcb[0], 0);
        wait_idle(0, 200);
        chk("single_low_cycles", lowcnt, 36);
        chk("single_sclk_pulses", sclk_rises, 8);
        chk("single_sclk_period", r2 - r1, 4);
        ex = '{8'h2A};
        check_bytes("single", ex);

        // Command then two data bytes in one select window
        clear_stats();
        valid[0] = 1'b1; data_in[0] = 8'h2C; dc_in[0] = 1'b0; tick_obs();
        data_in[0] = 8'hF8; dc_in[0] = 1'b1; tick_obs();
        data_in[0] = 8'h00; tick_obs();
        valid[0] = 1'b0;
        wait_idle(0, 400);
        chk("burst3_csb_falls", falls, 1);
        chk("burst3_csb_rises", csb_rises, 1);
        chk("burst3_low_cycles", lowcnt, 100);
        ex = '{8'h2C, 8'hF8, 8'h00};
        check_bytes("burst3", ex);

        // Six bytes with i_valid held: back-pressure from the full FIFO
        clear_stats();
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        k = 0; n = 0; acc5 = 0;
        valid[0] = 1'b1; dc_in[0] = 1'b1;
        while (k < 6 && n < 300) begin
            data_in[0] = vals[k];
            acc = ready[0];
            tick_obs();
            n++;
            if (acc) begin
                k++;
                if (k == 5) begin
                    acc5 = cyc;
                    chk("full_ready_low", ready[0], 0);
                end
                if (k == 6) chk("full_sixth_delay", cyc - acc5, 32);
            end
        end
        valid[0] = 1'b0;
        chk("full_all_accepted", k, 6);
        wait_idle(0, 600);
        chk("full_low_cycles", lowcnt, 196);
        ex = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        check_bytes("full", ex);

        // Reset at the 3rd spi_clk rise of 0xA5
        clear_stats();
        valid[0] = 1'b1; data_in[0] = 8'hA5; dc_in[0] = 1'b1; tick_obs();
        valid[0] = 1'b0;
        n = 0;
        while (sclk_rises < 3 && n < 100) begin
            tick_obs();
            n++;
        end
        chk("abort_reached_third_rise", sclk_rises, 3);
        rstb = 1'b0;
        #1;
        chk("abort_csb", csb[0], 1);
        chk("abort_spi_clk", sclk[0], 0);
        chk("abort_busy", busy[0], 0);
        chk("abort_ready", ready[0], 1);
        tick(); tick();
        rstb = 1'b1;
        clear_stats();
        repeat (40) tick_obs();
        chk("abort_no_sclk", sclk_rises, 0);
        chk("abort_no_csb", falls, 0);
        chk("abort_no_bytes", mon_q.size(), 0);

        // Receive 0x5A while sending 0xFF
        clear_stats();
        pat = 8'h5A; got = 8'h00; pulses = 0; idx = 0; n = 0;
        spi_miso = pat[7];
        valid[0] = 1'b1; data_in[0] = 8'hFF; dc_in[0] = 1'b1; tick_obs();
        valid[0] = 1'b0;
        while (busy[0] && n < 200) begin
            ps = sclk[0];
            tick_obs();
            n++;
            if (!ps && sclk[0]) begin
                idx++;
                spi_miso = (idx < 8) ? pat[7 - idx] : 1'b0;
            end
            if (rxv[0]) begin
                pulses++;
                got = rxd[0];
            end
        end
        spi_miso = 1'b0;
        chk("rx_idle", busy[0], 0);
        chk("rx_valid_pulses", pulses, RxEn ? 1 : 0);
        chk("rx_data_final", rxd[0], RxEn ? 8'h5A : 8'h00);
        chk("rx_data_at_pulse", got, RxEn ? 8'h5A : 8'h00);
        ex = '{8'hFF};
        check_bytes("rx_tx", ex);

        // CLK_DIV=1 lane: 0x81
        valid[1] = 1'b1; data_in[1] = 8'h81; dc_in[1] = 1'b0; tick();
        valid[1] = 1'b0;
        tick();
        chk("div1_csb_fall", csb[1], 0);
        low = 1; tog = 0; b = 8'h00; n = 0;
        while (!csb[1] && n < 100) begin
            ps = sclk[1];
            tick();
            n++;
            if (!csb[1]) low++;
            if (ps != sclk[1]) tog++;
            if (!ps && sclk[1]) b = {b[6:0], mosi[1]};
        end
        chk("div1_low_cycles", low, 18);
        chk("div1_toggles", tog, 16);
        chk("div1_byte", b, 8'h81);
        wait_idle(1, 50);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
